// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: controller state and pipeline-register indices.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_AES_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } ctrl_state_e;

    localparam logic [1:0] STG_IFID  = 2'd0;
    localparam logic [1:0] STG_IDEX  = 2'd1;
    localparam logic [1:0] STG_EXMEM = 2'd2;
    localparam logic [1:0] STG_MEMWB = 2'd3;

endpackage

// File: rtl/lu_hazard_det.sv
// Load-use hazard compare: a load in EX writes a register that the instruction in ID reads.
module lu_hazard_det #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_to_reg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              lu_hazard
);

    // x0 is never a real dependency, so a load targeting it never stalls.
    assign lu_hazard = ex_mem_to_reg && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers, PC enable and AES launch.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int AES_TIMEOUT = 64,
    parameter int DRAIN_CYC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ex_mem_to_reg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              branch_taken,
    input  logic              ex_aes_op,
    input  logic              aes_done,
    output logic              pc_en,
    output logic [3:0]        stg_en,
    output logic [3:0]        stg_clr,
    output logic              aes_start,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_MAX = (AES_TIMEOUT > DRAIN_CYC) ? AES_TIMEOUT : DRAIN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(AES_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_INI = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             draining_q, draining_d;
    logic             tmo_set;
    logic             lu_hazard;
    logic             aes_launch;
    logic             aes_finish;

    lu_hazard_det #(.REG_AW(REG_AW)) u_lu_hazard_det (
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rd         (ex_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .lu_hazard     (lu_hazard)
    );

    // One counter serves both the AES timeout (counts up) and the drain budget (counts down).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            draining_q  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            draining_q <= draining_d;
            if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign aes_launch = ex_aes_op && !branch_taken;
    assign aes_finish = aes_done || (cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        draining_d = draining_q;
        tmo_set    = 1'b0;
        pc_en      = 1'b0;
        stg_en     = 4'h0;
        stg_clr    = 4'hF;
        aes_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                draining_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_DRAIN: begin
                pc_en   = (state_q == ST_RUN);
                stg_en  = 4'hF;
                stg_clr = 4'h0;
                stg_clr[STG_IFID] = (state_q == ST_DRAIN);

                if (branch_taken) begin
                    pc_en              = 1'b1;
                    stg_clr[STG_IFID]  = 1'b1;
                    stg_clr[STG_IDEX]  = 1'b1;
                end else if (ex_aes_op) begin
                    aes_start          = 1'b1;
                    pc_en              = 1'b0;
                    stg_en[STG_IFID]   = 1'b0;
                    stg_en[STG_IDEX]   = 1'b0;
                    stg_clr            = 4'h0;
                    stg_clr[STG_EXMEM] = 1'b1;
                end else if (lu_hazard) begin
                    pc_en              = 1'b0;
                    stg_en[STG_IFID]   = 1'b0;
                    stg_clr[STG_IFID]  = 1'b0;
                    stg_clr[STG_IDEX]  = 1'b1;
                end

                if (aes_launch) begin
                    state_d = ST_AES_WAIT;
                    cnt_d   = '0;
                end else if (state_q == ST_RUN) begin
                    if (!start) begin
                        state_d    = ST_DRAIN;
                        cnt_d      = DRAIN_INI;
                        draining_d = 1'b1;
                    end
                end else if (branch_taken || !lu_hazard) begin
                    // A stalled drain cycle issues no bubble, so it does not consume budget.
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_AES_WAIT: begin
                stg_en             = 4'h0;
                stg_en[STG_EXMEM]  = 1'b1;
                stg_en[STG_MEMWB]  = 1'b1;
                stg_clr            = 4'h0;
                stg_clr[STG_EXMEM] = 1'b1;
                cnt_d              = cnt_q + CNT_ONE;

                if (aes_finish) begin
                    pc_en   = 1'b1;
                    stg_en  = 4'hF;
                    stg_clr = 4'h0;
                    if (!aes_done) begin
                        tmo_set            = 1'b1;
                        stg_clr[STG_IDEX]  = 1'b1;
                        stg_clr[STG_EXMEM] = 1'b1;
                    end
                    // A stop requested during the op, or an op launched while draining, ends in DRAIN.
                    if (start && !draining_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_DRAIN;
                        cnt_d      = DRAIN_INI;
                        draining_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
